// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and reset/step constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_STEP_DEFAULT = 1;
  localparam logic [31:0] RESET_PC        = 32'd0;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for a fetched instruction, its PC and PC+step.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc_plus,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      instr   <= '0;
      pc      <= RESET_PC;
      pc_plus <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= in_instr;
      pc      <= in_pc;
      pc_plus <= in_pc_plus;
    end else if (flush) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding memory request, one-entry decode buffer,
// redirect handling with stale-response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT,
  parameter int unsigned IMEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_cur,
  output logic [31:0]        pc_next,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus,
  output logic [31:0]        if_count
);

  fetch_state_t state, state_next;
  logic [31:0]  req_pc;
  logic [31:0]  req_pc_plus;
  logic [31:0]  pc_next_c;
  logic         enter_req;
  logic         buf_load;
  logic         buf_flush;
  logic         count_inc;
  logic         buf_valid;

  assign req_pc_plus = req_pc + 32'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_pc   <= RESET_PC;
      if_count <= '0;
    end else begin
      state <= state_next;
      if (enter_req)
        req_pc <= redirect_valid ? redirect_target : pc_cur;
      if (count_inc)
        if_count <= if_count + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    enter_req  = 1'b0;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
    count_inc  = 1'b0;
    pc_next_c  = redirect_valid ? redirect_target : pc_cur;
    case (state)
      IDLE: begin
        state_next = REQ;
        enter_req  = 1'b1;
      end
      REQ: begin
        if (redirect_valid) begin
          // ack with redirect re-issues at the target; without ack the old request must drain
          if (imem_ack) enter_req = 1'b1;
          else          state_next = DROP;
        end else if (imem_ack) begin
          state_next = HOLD;
          buf_load   = 1'b1;
          pc_next_c  = req_pc_plus;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = REQ;
          enter_req  = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || if_ready) begin
          state_next = REQ;
          enter_req  = 1'b1;
          buf_flush  = 1'b1;
          count_inc  = !redirect_valid;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are forced quiet while rst is high, even on the first reset cycle.
  assign pc_next   = rst ? RESET_PC : pc_next_c;
  assign imem_req  = !rst && (state == REQ || state == DROP);
  assign imem_addr = req_pc[IMEM_AW-1:0];
  assign if_valid  = buf_valid && !rst;

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .flush      (buf_flush),
    .in_instr   (imem_rdata),
    .in_pc      (req_pc),
    .in_pc_plus (req_pc_plus),
    .valid      (buf_valid),
    .instr      (if_instr),
    .pc         (if_pc),
    .pc_plus    (if_pc_plus)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; models the external PC register.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur = 32'd0;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus;
  logic [31:0] if_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pc_cur <= pc_next;

  fetch_unit #(.PC_STEP(1), .IMEM_AW(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus      (if_pc_plus),
    .if_count        (if_count)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_target = '0; if_ready = 1'b1;
    next_cycle(); next_cycle(); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", if_instr); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
    checks++; if (if_pc_plus !== 32'd0) begin errors++; $display("FAIL rst_pc_plus got %h exp 0", if_pc_plus); end
    checks++; if (if_count !== 32'd0) begin errors++; $display("FAIL rst_count got %h exp 0", if_count); end
    checks++; if (pc_next !== 32'd0) begin errors++; $display("FAIL rst_pc_next got %h exp 0", pc_next); end
  endtask

  task automatic test_sequential();
    next_cycle(); rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); imem_ack = 1'b1; imem_rdata = mem(32'(i)); #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %b exp 1", i, imem_req); end
      checks++; if (imem_addr !== 12'(i)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, 12'(i)); end
      checks++; if (pc_next !== 32'(i + 1)) begin errors++; $display("FAIL seq_pc_next[%0d] got %h exp %h", i, pc_next, 32'(i + 1)); end
      next_cycle(); imem_ack = 1'b0; #1;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, if_valid); end
      checks++; if (if_pc !== 32'(i)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, if_pc, 32'(i)); end
      checks++; if (if_instr !== mem(32'(i))) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, if_instr, mem(32'(i))); end
      checks++; if (if_pc_plus !== 32'(i + 1)) begin errors++; $display("FAIL seq_pc_plus[%0d] got %h exp %h", i, if_pc_plus, 32'(i + 1)); end
      checks++; if (if_count !== 32'(i)) begin errors++; $display("FAIL seq_count[%0d] got %h exp %h", i, if_count, 32'(i)); end
    end
  endtask

  task automatic test_wait();
    for (int k = 0; k < 4; k++) begin
      next_cycle(); imem_ack = (k == 3); imem_rdata = mem(32'd4); #1;
      if (k == 0) begin
        checks++; if (if_count !== 32'd4) begin errors++; $display("FAIL seq_final_count got %h exp 4", if_count); end
      end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d] got %b exp 1", k, imem_req); end
      checks++; if (imem_addr !== 12'd4) begin errors++; $display("FAIL wait_addr[%0d] got %h exp 004", k, imem_addr); end
      checks++; if (pc_next !== ((k == 3) ? 32'd5 : 32'd4)) begin errors++; $display("FAIL wait_pc_next[%0d] got %h exp %h", k, pc_next, (k == 3) ? 32'd5 : 32'd4); end
    end
  endtask

  task automatic test_stall();
    for (int j = 0; j < 5; j++) begin
      next_cycle(); imem_ack = 1'b0; if_ready = (j == 4); #1;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", j, if_valid); end
      checks++; if (if_pc !== 32'd4) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 4", j, if_pc); end
      checks++; if (if_instr !== mem(32'd4)) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", j, if_instr, mem(32'd4)); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", j, imem_req); end
      checks++; if (if_count !== 32'd4) begin errors++; $display("FAIL stall_count[%0d] got %h exp 4", j, if_count); end
      checks++; if (pc_next !== 32'd5) begin errors++; $display("FAIL stall_pc_next[%0d] got %h exp 5", j, pc_next); end
    end
  endtask

  task automatic test_redirect_drop();
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'h40; #1;
    checks++; if (imem_addr !== 12'd5) begin errors++; $display("FAIL drop_addr0 got %h exp 005", imem_addr); end
    checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL drop_pc_next0 got %h exp 40", pc_next); end
    next_cycle(); redirect_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 12'd5) begin errors++; $display("FAIL drop_addr1 got %h exp 005", imem_addr); end
    checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL drop_pc_next1 got %h exp 40", pc_next); end
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    next_cycle(); imem_ack = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drop_stale_valid got %b exp 0", if_valid); end
    checks++; if (imem_addr !== 12'h040) begin errors++; $display("FAIL drop_new_addr got %h exp 040", imem_addr); end
    next_cycle(); imem_ack = 1'b1; imem_rdata = mem(32'h40); #1;
    checks++; if (pc_next !== 32'h41) begin errors++; $display("FAIL drop_pc_next2 got %h exp 41", pc_next); end
    next_cycle(); imem_ack = 1'b0; if_ready = 1'b0; #1;
    checks++; if (if_pc !== 32'h40) begin errors++; $display("FAIL drop_if_pc got %h exp 40", if_pc); end
    checks++; if (if_instr !== mem(32'h40)) begin errors++; $display("FAIL drop_if_instr got %h exp %h", if_instr, mem(32'h40)); end
    checks++; if (if_count !== 32'd5) begin errors++; $display("FAIL drop_count got %h exp 5", if_count); end
  endtask

  task automatic test_redirect_hold();
    next_cycle(); if_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; #1;
    checks++; if (pc_next !== 32'h80) begin errors++; $display("FAIL hold_rd_pc_next got %h exp 80", pc_next); end
    next_cycle(); redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem(32'h80); #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hold_rd_flush got %b exp 0", if_valid); end
    checks++; if (if_count !== 32'd5) begin errors++; $display("FAIL hold_rd_count got %h exp 5", if_count); end
    checks++; if (imem_addr !== 12'h080) begin errors++; $display("FAIL hold_rd_addr got %h exp 080", imem_addr); end
    next_cycle(); imem_ack = 1'b0; #1;
    checks++; if (if_pc !== 32'h80) begin errors++; $display("FAIL hold_rd_if_pc got %h exp 80", if_pc); end
    checks++; if (if_pc_plus !== 32'h81) begin errors++; $display("FAIL hold_rd_pc_plus got %h exp 81", if_pc_plus); end
  endtask

  task automatic test_reset_mid();
    next_cycle(); #1;
    checks++; if (imem_addr !== 12'h081) begin errors++; $display("FAIL mid_addr got %h exp 081", imem_addr); end
    checks++; if (if_count !== 32'd6) begin errors++; $display("FAIL mid_count got %h exp 6", if_count); end
    next_cycle(); rst = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b exp 0", imem_req); end
    checks++; if (pc_next !== 32'd0) begin errors++; $display("FAIL mid_rst_pc_next got %h exp 0", pc_next); end
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0 || if_pc_plus !== 32'd0)
      begin errors++; $display("FAIL mid_rst_buf got %b/%h/%h/%h exp 0", if_valid, if_instr, if_pc, if_pc_plus); end
    checks++; if (if_count !== 32'd0) begin errors++; $display("FAIL mid_rst_count got %h exp 0", if_count); end
    next_cycle(); rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_idle_req got %b exp 0", imem_req); end
    next_cycle(); imem_ack = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got %b exp 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'd0) begin errors++; $display("FAIL mid_restart got %b/%h exp 1/000", imem_req, imem_addr); end
    next_cycle(); imem_ack = 1'b1; imem_rdata = mem(32'd0); #1;
    checks++; if (pc_next !== 32'd1) begin errors++; $display("FAIL mid_pc_next got %h exp 1", pc_next); end
    next_cycle(); imem_ack = 1'b0; if_ready = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin errors++; $display("FAIL mid_first got %b/%h exp 1/0", if_valid, if_pc); end
    checks++; if (if_instr !== mem(32'd0)) begin errors++; $display("FAIL mid_instr got %h exp %h", if_instr, mem(32'd0)); end
  endtask

  task automatic test_wrap();
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF; #1;
    next_cycle(); redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem(32'hFFFF_FFFF); #1;
    checks++; if (imem_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_addr got %h exp fff", imem_addr); end
    checks++; if (pc_next !== 32'd0) begin errors++; $display("FAIL wrap_pc_next got %h exp 0", pc_next); end
    next_cycle(); imem_ack = 1'b0; #1;
    checks++; if (if_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_if_pc got %h exp ffffffff", if_pc); end
    checks++; if (if_pc_plus !== 32'd0) begin errors++; $display("FAIL wrap_pc_plus got %h exp 0", if_pc_plus); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_redirect_drop();
    test_redirect_hold();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_STEP, default 1: PC increment per instruction (word-addressed instruction memory).
REQ-002 Parameter IMEM_AW, default 12: instruction memory address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 pc_cur  in  32  current value held in the PC register.
REQ-006 pc_next  out  32  next value written into the PC register every cycle; equals pc_cur when holding.
REQ-007 imem_req  out  1  instruction memory request; held high until imem_ack.
REQ-008 imem_addr  out  IMEM_AW  request address, stable while imem_req=1.
REQ-009 imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in the same cycle; ignored while imem_req=0.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 redirect_valid  in  1  branch/jump taken; single-cycle pulse from downstream.
REQ-012 redirect_target  in  32  new PC when redirect_valid=1.
REQ-013 if_valid  out  1  if_instr/if_pc/if_pc_plus valid to decode.
REQ-014 if_ready  in  1  decode accepts; transfer when if_valid && if_ready.
REQ-015 if_instr, if_pc, if_pc_plus  out  32 each  instruction, its PC, and its PC+PC_STEP.
REQ-016 if_count  out  32  number of completed decode transfers.

Function
REQ-017 Four states: IDLE, REQ (request outstanding), HOLD (instruction buffered), DROP (stale request outstanding; response discarded).
REQ-018 imem_req SHALL be 1 exactly in REQ and DROP; imem_addr = req_pc[IMEM_AW-1:0], with req_pc an internal 32-bit register.
REQ-019 On every entry into REQ, req_pc SHALL load redirect_valid ? redirect_target : pc_cur.
REQ-020 IDLE -> REQ unconditionally on the first cycle after reset deassertion.
REQ-021 REQ, imem_ack=1, redirect_valid=0 -> HOLD; buffer loads if_instr=imem_rdata, if_pc=req_pc, if_pc_plus=req_pc+PC_STEP; pc_next=req_pc+PC_STEP.
REQ-022 REQ, imem_ack=0, redirect_valid=0: stay REQ; pc_next=pc_cur.
REQ-023 REQ, redirect_valid=1, imem_ack=1: discard data; stay REQ (new request, req_pc=redirect_target); pc_next=redirect_target.
REQ-024 REQ, redirect_valid=1, imem_ack=0 -> DROP; pc_next=redirect_target; req_pc and imem_addr unchanged.
REQ-025 DROP: pc_next=redirect_valid ? redirect_target : pc_cur; on imem_ack discard data -> REQ.
REQ-026 HOLD: if_valid=1; buffer contents stable; pc_next=pc_cur.
REQ-027 HOLD, if_ready=1, redirect_valid=0 -> REQ; if_valid low next cycle; if_count increments by 1.
REQ-028 HOLD, redirect_valid=1 (with either if_ready value) -> REQ with target; buffered instruction flushed; transfer not counted; pc_next=redirect_target.
REQ-029 Redirect has priority over every other event in every state; IDLE with redirect_valid=1 -> REQ with req_pc=redirect_target.
REQ-030 Adders are 32-bit modulo 2^32; 0xFFFFFFFF+1 wraps to 0; if_count wraps from 0xFFFFFFFF to 0.
REQ-031 Latency: instruction visible on if_valid in the cycle after imem_ack; at most one request outstanding.

Reset
REQ-032 While rst=1: state IDLE, imem_req=0, if_valid=0, if_instr/if_pc/if_pc_plus=0, req_pc=0, if_count=0, pc_next=0.
REQ-033 rst during REQ or DROP SHALL abandon the outstanding request; an imem_ack arriving after reset and before the next request SHALL be ignored.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enumeration, PC_STEP default, and RESET_PC=32'd0.
REQ-035 One sub-module, fetch_buf: one-entry instruction/PC holding register with load, flush, and valid flag.

Verification
REQ-036 Reset, 0-wait memory, if_ready=1 -> fetches from addresses 0,1,2,3; if_pc 0,1,2,3; if_count=4; pc_next sequence 1,2,3,4.
REQ-037 imem_ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; pc_next=pc_cur throughout.
REQ-038 if_ready=0 for 5 cycles in HOLD -> if_valid/if_instr/if_pc held; no new request; if_count unchanged.
REQ-039 redirect to 0x40 while REQ without ack -> DROP; stale ack data never appears on if_valid; next request addr 0x40; if_pc=0x40.
REQ-040 redirect to 0x80 in HOLD with if_ready=1 -> buffered instruction flushed; if_count unchanged; next if_pc=0x80.
REQ-041 rst asserted mid-REQ, ack arrives during reset -> all outputs zero; fetch restarts at address 0.
